noc_injector: RTL and testbench
===============================

// Module: noc_injector
// PURPOSE
//  Source-side network interface feeding a router input port. Buffers 16-bit flits from a local
//  core in a small FIFO and forwards them to the router's valid_i/data_i. Credit-based flow
//  control: credit_i is driven by the router's credit_o.
// PARAMETERS
//  DATA_W        16  flit width; must equal the router data width
//  FIFO_DEPTH    4   local flit FIFO entries; power of 2, >= 2
//  INIT_CREDITS  4   router input buffer depth; credit counter value after reset
//  CRED_W        $clog2(INIT_CREDITS+1)  localparam, credit counter width
// PORTS
//  clk              in   1       clock; all state updates on posedge
//  rst              in   1       synchronous, active-high reset
//  src_valid_i      in   1       core presents a flit
//  src_data_i       in   DATA_W  core flit
//  src_ready_o      out  1       FIFO can accept; push = src_valid_i & src_ready_o
//  valid_o          out  1       to router valid_i; one flit per high cycle
//  data_o           out  DATA_W  to router data_i
//  credit_i         in   1       one credit returned per high cycle (from router credit_o)
//  credit_cnt_o     out  CRED_W  current credits available
//  fifo_cnt_o       out  clog2(FIFO_DEPTH)+1  flits held in the FIFO
//  credit_err_o     out  1       sticky: credit returned while counter already at INIT_CREDITS
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - FIFO pointers and count = 0; credits = INIT_CREDITS.
//  - valid_o=0, data_o=0, credit_err_o=0.
//  - src_ready_o=0 while rst is high.
//  src_ready_o = !rst && (fifo_cnt < FIFO_DEPTH); combinational from registered count only.
//  - A push never depends on a same-cycle pop.
//  send = (fifo_cnt > 0) && (credits > 0), evaluated on registered state.
//  - At posedge with send: pop FIFO head into data_o, valid_o<=1, credits decrement.
//  - At posedge without send: valid_o<=0, data_o holds its previous value.
//  Latency: a flit pushed at edge N, into an empty FIFO with credits>0, has valid_o=1 after edge N+1.
//  - Back-to-back pushes with sufficient credits give one flit per cycle on valid_o.
//  Flits leave in push order. Pointers wrap modulo FIFO_DEPTH. No flit is dropped or duplicated.
//  Credit update per edge:
//  - send & credit_i: count unchanged.
//  - send only: -1.
//  - credit_i only: +1, saturating at INIT_CREDITS.
//  - credit_i arriving at INIT_CREDITS without send: count stays, credit_err_o<=1 until reset.
//  Credits never underflow: send is blocked at 0.
//  FIFO count per edge:
//  - push & send: unchanged.
//  - push only: +1.
//  - send only: -1.
//  - Push and pop in the same cycle are allowed at any fill level except push when full (ready=0).
//  Reset mid-operation:
//  - Discards all buffered flits. Credits restore to INIT_CREDITS.
//  - valid_o=0 on the cycle after the reset edge.
//  - The router is reset together with this block.
// TESTING
//  1 Assert rst 2 cycles -> valid_o=0, data_o=0, credit_cnt_o=4, fifo_cnt_o=0, credit_err_o=0;
//    src_ready_o=0 during reset, =1 after.
//  2 Push A001,A002,A003 on consecutive edges, no credit_i -> valid_o high 3 consecutive cycles
//    starting one cycle after the first push, data A001..A003, credit_cnt_o ends at 1.
//  3 Push 6 flits, no credit_i -> exactly 4 sent, then valid_o=0, fifo_cnt_o=2;
//    pulse credit_i once -> 5th flit sent next cycle, credit_cnt_o returns to 0.
//  4 Sustained traffic with credit_i high every cycle from the 1st send -> credit_cnt_o constant;
//    one flit per cycle; pointers wrap several times; output order equals push order.
//  5 With credits=4 and FIFO empty, pulse credit_i -> credit_cnt_o stays 4, credit_err_o=1 and
//    stays 1 until rst.
//  6 Fill FIFO to 4 with credits=0 -> src_ready_o=0, src_valid_i ignored;
//    assert rst mid-stream -> FIFO empty, credit_cnt_o=4, valid_o=0 after the reset edge.

Source files
------------

// File: rtl/noc_injector.sv
// noc_injector: source-side network interface for one router input port.
// Flits from the local core are held in a small FIFO and forwarded to the router
// only while credits are available. Each flit sent spends one credit. The router
// returns one credit per high cycle of credit_i.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   src_valid_i    core presents a flit on src_data_i
//   src_ready_o    FIFO has room (driven only from the registered count)
//   valid_o        one flit per high cycle to the router
//   data_o         flit to the router (holds its value while valid_o is low)
//   credit_i       one credit returned per high cycle
//   credit_cnt_o   credits currently available
//   fifo_cnt_o     flits currently buffered
//   credit_err_o   sticky: credit returned while the counter was already full
module noc_injector #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned INIT_CREDITS = 4,
  localparam int unsigned CRED_W      = $clog2(INIT_CREDITS + 1),
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid_i,
  input  logic [DATA_W-1:0] src_data_i,
  output logic              src_ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              credit_i,
  output logic [CRED_W-1:0] credit_cnt_o,
  output logic [CNT_W-1:0]  fifo_cnt_o,
  output logic              credit_err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CRED_W-1:0] cred_q, cred_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push, send;

  // Ready looks only at the registered count, so a push never relies on a same-cycle pop.
  assign src_ready_o = !rst && (cnt_q < CNT_W'(FIFO_DEPTH));
  assign push        = src_valid_i && src_ready_o;
  assign send        = (cnt_q != '0) && (cred_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    cred_d   = cred_q;
    err_d    = err_q;
    valid_d  = send;
    data_d   = data_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (send) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      data_d   = mem_q[rd_ptr_q];
    end

    case ({push, send})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({send, credit_i})
      2'b10: cred_d = cred_q - CRED_W'(1);
      2'b01: begin
        // A returned credit with a full counter means the router over-returned.
        if (cred_q == CRED_W'(INIT_CREDITS)) err_d = 1'b1;
        else                                  cred_d = cred_q + CRED_W'(1);
      end
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cred_q   <= CRED_W'(INIT_CREDITS);
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cred_q   <= cred_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset; only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= src_data_i;
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign credit_cnt_o = cred_q;
  assign fifo_cnt_o   = cnt_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_noc_injector.sv
// Self-checking bench for noc_injector. A queue-based reference model applies the
// credit and FIFO rules each edge; every test compares the DUT with it inline.
module tb_noc_injector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_valid_i = 1'b0;
  logic [15:0] src_data_i = '0;
  logic        src_ready_o;
  logic        valid_o;
  logic [15:0] data_o;
  logic        credit_i = 1'b0;
  logic [2:0]  credit_cnt_o;
  logic [2:0]  fifo_cnt_o;
  logic        credit_err_o;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [15:0] mq[$];
  int          m_cred = 4;
  logic        m_valid = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_err = 1'b0;

  noc_injector dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid_i  (src_valid_i),
    .src_data_i   (src_data_i),
    .src_ready_o  (src_ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .credit_i     (credit_i),
    .credit_cnt_o (credit_cnt_o),
    .fifo_cnt_o   (fifo_cnt_o),
    .credit_err_o (credit_err_o)
  );

  always #5 clk = ~clk;

  task automatic apply_reset(input int n);
    rst = 1'b1;
    src_valid_i = 1'b0;
    credit_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    mq.delete();
    m_cred = 4;
    m_valid = 1'b0;
    m_data = '0;
    m_err = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then wait past the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic c);
    bit push, send;
    src_valid_i = v;
    src_data_i = d;
    credit_i = c;
    push = v && (mq.size() < 4);
    send = (mq.size() > 0) && (m_cred > 0);
    if (send) begin
      m_data = mq.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (push) mq.push_back(d);
    if (send && !c) m_cred--;
    else if (!send && c) begin
      if (m_cred == 4) m_err = 1'b1;
      else m_cred++;
    end
    @(posedge clk);
    #1;
    src_valid_i = 1'b0;
    credit_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (src_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_during: got %b exp 0", src_ready_o);
    end
    apply_reset(2);
    checks++;
    if (valid_o !== 1'b0 || data_o !== 16'h0 || credit_cnt_o !== 3'd4 ||
        fifo_cnt_o !== 3'd0 || credit_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h cred=%0d cnt=%0d err=%b exp v=0 d=0 cred=4 cnt=0 err=0",
               valid_o, data_o, credit_cnt_o, fifo_cnt_o, credit_err_o);
    end
    checks++;
    if (src_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after: got %b exp 1", src_ready_o);
    end
  endtask

  task automatic test_burst();
    logic [15:0] seen[$];
    apply_reset(1);
    for (int i = 0; i < 8; i++) begin
      if (i < 3) step(1'b1, 16'hA001 + 16'(i), 1'b0);
      else       step(1'b0, 16'h0, 1'b0);
      checks++;
      if (valid_o !== m_valid || (m_valid && data_o !== m_data)) begin
        failures++;
        $display("FAIL burst_out[%0d]: got v=%b d=%h exp v=%b d=%h", i, valid_o, data_o,
                 m_valid, m_data);
      end
      if (valid_o === 1'b1) seen.push_back(data_o);
      // First push lands at cycle 0, so flits must appear on cycles 1..3 exactly.
      checks++;
      if (valid_o !== ((i >= 1 && i <= 3) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL burst_timing[%0d]: got v=%b", i, valid_o);
      end
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 16'hA001 || seen[2] !== 16'hA003) begin
      failures++;
      $display("FAIL burst_order: got %0d flits exp A001..A003", seen.size());
    end
    checks++;
    if (credit_cnt_o !== 3'd1) begin
      failures++;
      $display("FAIL burst_credit: got %0d exp 1", credit_cnt_o);
    end
  endtask

  task automatic test_credit_block();
    int sent = 0;
    apply_reset(1);
    for (int i = 0; i < 10; i++) begin
      step((i < 6) ? 1'b1 : 1'b0, 16'hB000 + 16'(i), 1'b0);
      if (valid_o === 1'b1) sent++;
      checks++;
      if (valid_o !== m_valid || (m_valid && data_o !== m_data) ||
          credit_cnt_o !== 3'(m_cred) || fifo_cnt_o !== 3'(mq.size())) begin
        failures++;
        $display("FAIL block_cycle[%0d]: got v=%b d=%h cred=%0d cnt=%0d exp v=%b d=%h cred=%0d cnt=%0d",
                 i, valid_o, data_o, credit_cnt_o, fifo_cnt_o, m_valid, m_data, m_cred, mq.size());
      end
    end
    checks++;
    if (sent != 4 || valid_o !== 1'b0 || fifo_cnt_o !== 3'd2) begin
      failures++;
      $display("FAIL block_stall: got sent=%0d v=%b cnt=%0d exp sent=4 v=0 cnt=2", sent, valid_o,
               fifo_cnt_o);
    end
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'hB004 || credit_cnt_o !== 3'd0) begin
      failures++;
      $display("FAIL block_release: got v=%b d=%h cred=%0d exp v=1 d=b004 cred=0", valid_o, data_o,
               credit_cnt_o);
    end
  endtask

  task automatic test_sustained();
    logic [15:0] pushed[$];
    logic [15:0] seen[$];
    logic [15:0] d;
    bit bad = 0;
    apply_reset(1);
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      if (i < 36) pushed.push_back(d);
      step((i < 36) ? 1'b1 : 1'b0, d, (i >= 1) ? 1'b1 : 1'b0);
      if (valid_o === 1'b1) seen.push_back(data_o);
      checks++;
      if (valid_o !== m_valid || (m_valid && data_o !== m_data) || credit_cnt_o !== 3'd4) begin
        failures++;
        $display("FAIL sustained[%0d]: got v=%b d=%h cred=%0d exp v=%b d=%h cred=4", i, valid_o,
                 data_o, credit_cnt_o, m_valid, m_data);
      end
    end
    if (seen.size() != pushed.size()) bad = 1;
    else foreach (seen[k]) if (seen[k] !== pushed[k]) bad = 1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL sustained_order: got %0d flits exp %0d in push order", seen.size(),
               pushed.size());
    end
  endtask

  task automatic test_random();
    apply_reset(1);
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      checks++;
      if (valid_o !== m_valid || (m_valid && data_o !== m_data) ||
          credit_cnt_o !== 3'(m_cred) || fifo_cnt_o !== 3'(mq.size()) ||
          credit_err_o !== m_err || src_ready_o !== (mq.size() < 4)) begin
        failures++;
        $display("FAIL random[%0d]: got v=%b d=%h cred=%0d cnt=%0d err=%b rdy=%b exp v=%b d=%h cred=%0d cnt=%0d err=%b",
                 i, valid_o, data_o, credit_cnt_o, fifo_cnt_o, credit_err_o, src_ready_o,
                 m_valid, m_data, m_cred, mq.size(), m_err);
      end
    end
  endtask

  task automatic test_credit_err();
    apply_reset(1);
    step(1'b0, 16'h0, 1'b1);
    checks++;
    if (credit_cnt_o !== 3'd4 || credit_err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_set: got cred=%0d err=%b exp cred=4 err=1", credit_cnt_o, credit_err_o);
    end
    repeat (5) step(1'b1, 16'hC0DE, 1'b0);
    checks++;
    if (credit_err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %b exp 1", credit_err_o);
    end
    apply_reset(1);
    checks++;
    if (credit_err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: got %b exp 0", credit_err_o);
    end
  endtask

  task automatic test_full_reset();
    apply_reset(1);
    for (int i = 0; i < 9; i++) step((i < 8) ? 1'b1 : 1'b0, 16'hD000 + 16'(i), 1'b0);
    checks++;
    if (fifo_cnt_o !== 3'd4 || credit_cnt_o !== 3'd0 || src_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL full_state: got cnt=%0d cred=%0d rdy=%b exp cnt=4 cred=0 rdy=0", fifo_cnt_o,
               credit_cnt_o, src_ready_o);
    end
    step(1'b1, 16'hDEAD, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0);
    checks++;
    if (fifo_cnt_o !== 3'd4 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL full_ignore: got cnt=%0d v=%b exp cnt=4 v=0", fifo_cnt_o, valid_o);
    end
    apply_reset(1);
    checks++;
    if (fifo_cnt_o !== 3'd0 || credit_cnt_o !== 3'd4 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset: got cnt=%0d cred=%0d v=%b exp cnt=0 cred=4 v=0", fifo_cnt_o,
               credit_cnt_o, valid_o);
    end
    // Discarded flits must not reappear after reset.
    step(1'b1, 16'hE001, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'hE001) begin
      failures++;
      $display("FAIL midreset_flush: got v=%b d=%h exp v=1 d=e001", valid_o, data_o);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_credit_block();
    test_sustained();
    test_credit_err();
    test_full_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
